// File: rtl/dfb_spi_pkg.sv
// Shared constants, FSM state type and status packing for the DFB register / SPI master block.
// Optional auto chip-select is enabled by defining DFB_SPI_AUTOCS_EN.
package dfb_spi_pkg;

  localparam logic [3:0] OFF_ID   = 4'h0;
  localparam logic [3:0] OFF_DFB  = 4'h2;
  localparam logic [3:0] OFF_DATA = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h6;

  localparam logic [7:0] CTRL_RESET    = 8'h03;
  localparam logic       SPI_IDLE_MOSI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } spi_state_t;

  // Status byte layout seen by the CPU at the control offset.
  function automatic logic [7:0] status_byte(input logic busy, input logic overrun,
                                             input logic [1:0] ctrl);
    return {busy, overrun, 4'b0000, ctrl};
  endfunction

endpackage

// File: rtl/dfb_spi_regs_if.sv
// CPU-side register bus between the accelerator top-level decode and dfb_spi_regs.
interface dfb_spi_regs_if;

  logic       REG_SEL_n;
  logic       AS_n;
  logic       DS_n;
  logic       XRW;
  logic [3:0] ADDR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOE;

  modport master (
    output REG_SEL_n, AS_n, DS_n, XRW, ADDR, DIN,
    input  DOUT, DOE
  );

  modport slave (
    input  REG_SEL_n, AS_n, DS_n, XRW, ADDR, DIN,
    output DOUT, DOE
  );

endinterface

// File: rtl/dfb_spi_shifter.sv
// Mode-0 MSB-first SPI byte engine: bit tick generator, IDLE/LOAD/XFER/DONE FSM, tx/rx shifters.
// With DFB_SPI_AUTOCS_EN defined, also produces busy_cs to hold chip-select around each byte.
module dfb_spi_shifter
  import dfb_spi_pkg::*;
#(
  parameter int unsigned FAST_DIV = 2
) (
  input  logic       CLKOSC,
  input  logic       RST,
  input  logic       khz500,
  input  logic       start,
  input  logic       slow,
  input  logic [7:0] tx_in,
  input  logic       miso,
  output logic       busy,
  output logic [7:0] rx,
  output logic       sck,
  output logic       mosi
`ifdef DFB_SPI_AUTOCS_EN
  ,
  output logic       busy_cs
`endif
);

  localparam int unsigned DIV_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

  spi_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       phase_q;
  logic [7:0]       tx_sh_q;
  logic [7:0]       rx_sh_q;
  logic             slow_q;
  logic [2:0]       khz_q;
  logic             div_wrap_c;
  logic             tick_c;
  logic             start_c;
  logic             load_c;
  logic             shift_c;
  logic             done_c;

  // KHZ500 two-flop synchroniser plus one extra stage for rising-edge detect.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) khz_q <= 3'b000;
    else      khz_q <= {khz_q[1:0], khz500};
  end

  assign div_wrap_c = (div_q == DIV_W'(FAST_DIV - 1));
  assign tick_c     = slow_q ? (khz_q[1] & ~khz_q[2]) : div_wrap_c;

  // Free-running fast divider, restarted so XFER begins on a fresh half-bit.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST)                          div_q <= '0;
    else if (state_q == LOAD || div_wrap_c) div_q <= '0;
    else                               div_q <= div_q + DIV_W'(1);
  end

  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = XFER;
      XFER:    if (tick_c && phase_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    load_c  = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE:    start_c = start;
      LOAD:    load_c  = 1'b1;
      XFER:    shift_c = tick_c;
      DONE:    done_c  = 1'b1;
      default: ;
    endcase
  end

  // Even phases raise SCK and sample MISO; odd phases lower SCK and present the next bit.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      busy    <= 1'b0;
      slow_q  <= CTRL_RESET[1];
      tx_sh_q <= 8'hFF;
      rx_sh_q <= 8'hFF;
      rx      <= 8'hFF;
      sck     <= 1'b0;
      mosi    <= SPI_IDLE_MOSI;
      phase_q <= 4'd0;
    end else begin
      if (start_c) begin
        busy    <= 1'b1;
        slow_q  <= slow;
        tx_sh_q <= tx_in;
      end
      if (load_c) begin
        mosi    <= tx_sh_q[7];
        phase_q <= 4'd0;
      end
      if (shift_c) begin
        phase_q <= phase_q + 4'd1;
        if (!phase_q[0]) begin
          sck     <= 1'b1;
          rx_sh_q <= {rx_sh_q[6:0], miso};
        end else begin
          sck     <= 1'b0;
          mosi    <= tx_sh_q[6];
          tx_sh_q <= {tx_sh_q[6:0], 1'b1};
        end
      end
      if (done_c) begin
        rx   <= rx_sh_q;
        busy <= 1'b0;
        mosi <= SPI_IDLE_MOSI;
        sck  <= 1'b0;
      end
    end
  end

`ifdef DFB_SPI_AUTOCS_EN
  logic cs_pend_q;

  // Chip-select hold: on from LOAD, released on the first tick after DONE.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      busy_cs   <= 1'b0;
      cs_pend_q <= 1'b0;
    end else if (load_c) begin
      busy_cs   <= 1'b1;
      cs_pend_q <= 1'b0;
    end else if (done_c) begin
      cs_pend_q <= 1'b1;
    end else if (cs_pend_q && tick_c) begin
      busy_cs   <= 1'b0;
      cs_pend_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/dfb_spi_regs.sv
// DFB config register, SPI control/status registers and CPU bus synchroniser at F1DFB0-F1DFBF.
// Define DFB_SPI_AUTOCS_EN to drive SPI_CS_n low automatically around each byte.
module dfb_spi_regs
  import dfb_spi_pkg::*;
#(
  parameter int unsigned FAST_DIV  = 2,
  parameter logic [7:0]  ID_VALUE  = 8'h01,
  parameter logic [7:0]  DFB_RESET = 8'hFD
) (
  input  logic                 CLKOSC,
  input  logic                 RST,
  dfb_spi_regs_if.slave        bus,
  input  logic                 KHZ500,
  output logic [7:0]           REG_DFB,
  output logic                 SPI_SCK,
  output logic                 SPI_MOSI,
  input  logic                 SPI_MISO,
  output logic                 SPI_CS_n
);

  logic       acc_n_c;
  logic [2:0] acc_q;
  logic       strobe_c;
  logic       wr_c;
  logic       rd_c;
  logic       start_c;
  logic [1:0] ctrl_q;
  logic       overrun_q;
  logic       spi_busy;
  logic [7:0] spi_rx;

  assign acc_n_c = bus.AS_n | bus.DS_n | bus.REG_SEL_n;

  // acc_q[1:0] is the synchroniser; acc_q[2] delays it once more for falling-edge detect.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) acc_q <= 3'b111;
    else      acc_q <= {acc_q[1:0], acc_n_c};
  end

  assign strobe_c = acc_q[2] & ~acc_q[1];
  assign wr_c     = strobe_c & ~bus.XRW;
  assign rd_c     = strobe_c &  bus.XRW;
  assign start_c  = wr_c & (bus.ADDR == OFF_DATA) & ~spi_busy;

  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      REG_DFB   <= DFB_RESET;
      ctrl_q    <= CTRL_RESET[1:0];
      overrun_q <= 1'b0;
    end else begin
      if (wr_c && bus.ADDR == OFF_DFB)  REG_DFB <= bus.DIN;
      if (wr_c && bus.ADDR == OFF_CTRL) ctrl_q  <= bus.DIN[1:0];
      // A data write while busy wins over a status-read clear in the same cycle.
      if (wr_c && bus.ADDR == OFF_DATA && spi_busy) overrun_q <= 1'b1;
      else if (rd_c && bus.ADDR == OFF_CTRL)        overrun_q <= 1'b0;
    end
  end

  // Read path is deliberately unsynchronised so data is valid as soon as DS falls.
  assign bus.DOE = ~acc_n_c & bus.XRW;

  always_comb begin
    bus.DOUT = 8'hFF;
    unique case (bus.ADDR)
      OFF_ID:   bus.DOUT = ID_VALUE;
      OFF_DFB:  bus.DOUT = REG_DFB;
      OFF_DATA: bus.DOUT = spi_rx;
      OFF_CTRL: bus.DOUT = status_byte(spi_busy, overrun_q, ctrl_q);
      default:  bus.DOUT = 8'hFF;
    endcase
  end

`ifdef DFB_SPI_AUTOCS_EN
  logic busy_cs;
`endif

  dfb_spi_shifter #(
    .FAST_DIV (FAST_DIV)
  ) u_shifter (
    .CLKOSC  (CLKOSC),
    .RST     (RST),
    .khz500  (KHZ500),
    .start   (start_c),
    .slow    (ctrl_q[1]),
    .tx_in   (bus.DIN),
    .miso    (SPI_MISO),
    .busy    (spi_busy),
    .rx      (spi_rx),
    .sck     (SPI_SCK),
    .mosi    (SPI_MOSI)
`ifdef DFB_SPI_AUTOCS_EN
    ,
    .busy_cs (busy_cs)
`endif
  );

`ifdef DFB_SPI_AUTOCS_EN
  assign SPI_CS_n = ctrl_q[0] & ~busy_cs;
`else
  assign SPI_CS_n = ctrl_q[0];
`endif

endmodule

// File: tb/tb_dfb_spi_regs.sv
// Directed bench for dfb_spi_regs: reset, config write, fast loopback, overrun, slow mode, reset mid-byte.
module tb_dfb_spi_regs;
  import dfb_spi_pkg::*;

  localparam int unsigned FAST_DIV = 2;

  logic CLKOSC = 1'b0;
  logic RST    = 1'b0;
  logic KHZ500 = 1'b0;
  logic [7:0] REG_DFB;
  logic SPI_SCK, SPI_MOSI, SPI_MISO, SPI_CS_n;
  logic loop_en  = 1'b0;
  logic miso_drv = 1'b0;

  int checks = 0;
  int errors = 0;

  dfb_spi_regs_if bus ();

  dfb_spi_regs #(
    .FAST_DIV  (FAST_DIV),
    .ID_VALUE  (8'h01),
    .DFB_RESET (8'hFD)
  ) dut (
    .CLKOSC   (CLKOSC),
    .RST      (RST),
    .bus      (bus),
    .KHZ500   (KHZ500),
    .REG_DFB  (REG_DFB),
    .SPI_SCK  (SPI_SCK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .SPI_CS_n (SPI_CS_n)
  );

  always #5 CLKOSC = ~CLKOSC;
  always #40 KHZ500 = ~KHZ500;

  assign SPI_MISO = loop_en ? SPI_MOSI : miso_drv;

  // SCK monitor: cumulative edge counts, MOSI at each rise, gaps between edges.
  int         cyc       = 0;
  logic       sck_prev  = 1'b0;
  int         rise_cnt  = 0;
  int         edge_cnt  = 0;
  int         last_edge = 0;
  int         edge_gap  = 0;
  int         hi_width  = 0;
  logic [7:0] mosi_bits = 8'h00;

  always @(negedge CLKOSC) begin
    cyc      <= cyc + 1;
    sck_prev <= SPI_SCK;
    if (SPI_SCK && !sck_prev) begin
      rise_cnt  <= rise_cnt + 1;
      mosi_bits <= {mosi_bits[6:0], SPI_MOSI};
    end
    if (SPI_SCK != sck_prev) begin
      edge_cnt  <= edge_cnt + 1;
      edge_gap  <= cyc - last_edge;
      last_edge <= cyc;
    end
    if (!SPI_SCK && sck_prev) hi_width <= cyc - last_edge;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLKOSC);
    bus.ADDR = a; bus.DIN = d; bus.XRW = 1'b0;
    bus.REG_SEL_n = 1'b0; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    repeat (6) @(negedge CLKOSC);
    bus.REG_SEL_n = 1'b1; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    repeat (4) @(negedge CLKOSC);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
    @(negedge CLKOSC);
    bus.ADDR = a; bus.XRW = 1'b1;
    bus.REG_SEL_n = 1'b0; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    #2;
    d  = bus.DOUT;
    oe = bus.DOE;
    repeat (6) @(negedge CLKOSC);
    bus.REG_SEL_n = 1'b1; bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.XRW = 1'b0;
    repeat (4) @(negedge CLKOSC);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] st;
    logic       oe;
    int         n;
    n = 0;
    do begin
      bus_read(OFF_CTRL, st, oe);
      n++;
    end while (st[7] && n < 40);
    check(tag, {7'b0, st[7]}, 8'h00);
  endtask

  logic [7:0] rd;
  logic       oe;
  int         r0, e0, n;

  initial begin
    bus.REG_SEL_n = 1'b1; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    bus.XRW = 1'b0; bus.ADDR = 4'h0; bus.DIN = 8'h00;

    // Reset values
    repeat (3) @(negedge CLKOSC);
    RST = 1'b1;
    repeat (2) @(negedge CLKOSC);
    check("rst_reg_dfb", REG_DFB, 8'hFD);
    check("rst_cs_n", {7'b0, SPI_CS_n}, 8'h01);
    check("rst_mosi", {7'b0, SPI_MOSI}, 8'h01);
    check("rst_sck", {7'b0, SPI_SCK}, 8'h00);
    check("rst_doe", {7'b0, bus.DOE}, 8'h00);
    bus_read(OFF_ID, rd, oe);
    check("rd_id", rd, 8'h01);
    check("rd_id_doe", {7'b0, oe}, 8'h01);
    bus_read(OFF_CTRL, rd, oe);
    check("rd_ctrl_rst", rd, 8'h03);
    bus_read(OFF_DATA, rd, oe);
    check("rd_rx_rst", rd, 8'hFF);
    bus_read(4'h1, rd, oe);
    check("rd_off1", rd, 8'hFF);
    bus_read(4'hF, rd, oe);
    check("rd_offF", rd, 8'hFF);

    // Config write lands within 4 CLKOSC cycles of DS falling
    @(negedge CLKOSC);
    bus.ADDR = OFF_DFB; bus.DIN = 8'h35; bus.XRW = 1'b0;
    bus.REG_SEL_n = 1'b0; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    #1 check("wr_doe_low", {7'b0, bus.DOE}, 8'h00);
    repeat (4) @(posedge CLKOSC);
    #1 check("dfb_in_4cyc", REG_DFB, 8'h35);
    repeat (3) @(negedge CLKOSC);
    bus.REG_SEL_n = 1'b1; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    repeat (4) @(negedge CLKOSC);
    check("dfb_once", REG_DFB, 8'h35);
    bus_read(OFF_DFB, rd, oe);
    check("rd_dfb", rd, 8'h35);

    // Fast loopback, CS low
    bus_write(OFF_CTRL, 8'h00);
    bus_read(OFF_CTRL, rd, oe);
    check("rd_ctrl_00", rd, 8'h00);
    check("cs_sw_low", {7'b0, SPI_CS_n}, 8'h00);
    loop_en = 1'b1;
    r0 = rise_cnt;
    bus_write(OFF_DATA, 8'hA5);
    wait_idle("fast_busy_clear");
    check("fast_rises", 8'(rise_cnt - r0), 8'd8);
    check("fast_mosi_seq", mosi_bits, 8'hA5);
    check("fast_hi_width", 8'(hi_width), 8'(FAST_DIV));
    bus_read(OFF_DATA, rd, oe);
    check("fast_rx", rd, 8'hA5);

    // Overrun: second data write during a byte is dropped
    r0 = rise_cnt;
    bus_write(OFF_DATA, 8'h3C);
    bus_write(OFF_DATA, 8'h12);
    bus_read(OFF_CTRL, rd, oe);
    check("ovr_status", rd, 8'hC0);
    wait_idle("ovr_busy_clear");
    bus_read(OFF_CTRL, rd, oe);
    check("ovr_cleared", rd, 8'h00);
    check("ovr_mosi_seq", mosi_bits, 8'h3C);
    check("ovr_rises", 8'(rise_cnt - r0), 8'd8);
    bus_read(OFF_DATA, rd, oe);
    check("ovr_rx_untouched", rd, 8'h3C);

    // Slow mode: each SCK edge follows a KHZ500 rising edge (8 CLKOSC apart)
    loop_en  = 1'b0;
    miso_drv = 1'b0;
    bus_write(OFF_CTRL, 8'h02);
    e0 = edge_cnt;
    bus_write(OFF_DATA, 8'hFF);
    wait_idle("slow_busy_clear");
    check("slow_edges", 8'(edge_cnt - e0), 8'd16);
    check("slow_gap", 8'(edge_gap), 8'd8);
    check("slow_hi_width", 8'(hi_width), 8'd8);
    check("slow_mosi_seq", mosi_bits, 8'hFF);
    bus_read(OFF_DATA, rd, oe);
    check("slow_rx", rd, 8'h00);

    // Reset mid-byte (SCK high in phase 7)
    bus_write(OFF_CTRL, 8'h00);
    miso_drv = 1'b0;
    r0 = rise_cnt;
    bus_write(OFF_DATA, 8'h00);
    n = 0;
    while ((rise_cnt - r0) < 4 && n < 200) begin
      @(negedge CLKOSC);
      n++;
    end
    check("midrst_reached", {7'b0, n < 200}, 8'h01);
    RST = 1'b0;
    #1;
    check("midrst_sck", {7'b0, SPI_SCK}, 8'h00);
    check("midrst_mosi", {7'b0, SPI_MOSI}, 8'h01);
    check("midrst_cs_n", {7'b0, SPI_CS_n}, 8'h01);
    repeat (2) @(negedge CLKOSC);
    RST = 1'b1;
    repeat (2) @(negedge CLKOSC);
    check("midrst_dfb", REG_DFB, 8'hFD);
    bus_read(OFF_CTRL, rd, oe);
    check("midrst_status", rd, 8'h03);
    bus_read(OFF_DATA, rd, oe);
    check("midrst_rx", rd, 8'hFF);

    // Chip-select around a byte with software CS high
    loop_en = 1'b1;
    bus_write(OFF_CTRL, 8'h01);
    bus_write(OFF_DATA, 8'h81);
`ifdef DFB_SPI_AUTOCS_EN
    check("autocs_low", {7'b0, SPI_CS_n}, 8'h00);
`else
    check("cs_sw_high", {7'b0, SPI_CS_n}, 8'h01);
`endif
    wait_idle("cs_busy_clear");
    check("cs_after", {7'b0, SPI_CS_n}, 8'h01);
    bus_read(OFF_DATA, rd, oe);
    check("cs_rx", rd, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
